// File: rtl/artyz7_led_sequencer.sv
`default_nettype none
// ==== artyz7_led_sequencer : tick-stepped LED animation (off/blink/shift/bounce) with PWM brightness | rev 1.0 ====
module artyz7_led_sequencer #(
  parameter int NUM_LEDS     = 4,
  parameter int TICK_DIVIDER = 62_500_000,
  parameter int PWM_BITS     = 4
) (
  input  logic                clk_ext,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_mode,
  input  logic [PWM_BITS-1:0] cmd_level,
  output logic [NUM_LEDS-1:0] led,
  output logic                tick
);

  localparam int                  PRE_W     = $clog2(TICK_DIVIDER);
  localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(TICK_DIVIDER - 1);
  localparam logic [1:0]          MODE_OFF    = 2'd0;
  localparam logic [1:0]          MODE_BLINK  = 2'd1;
  localparam logic [1:0]          MODE_SHIFT  = 2'd2;
  localparam logic [1:0]          MODE_BOUNCE = 2'd3;
  localparam logic [NUM_LEDS-1:0] PAT_ONES  = '1;
  localparam logic [NUM_LEDS-1:0] PAT_FIRST = NUM_LEDS'(1);

  typedef enum logic {ST_RUN = 1'b0, ST_PENDING = 1'b1} state_t;

  state_t              state;
  logic [PRE_W-1:0]    prescaler;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] level;
  logic [PWM_BITS-1:0] pend_level;
  logic [1:0]          mode;
  logic [1:0]          pend_mode;
  logic [NUM_LEDS-1:0] pattern;
  logic [NUM_LEDS-1:0] step_pattern;
  logic [NUM_LEDS-1:0] init_pattern;
  logic                dir_up;
  logic                step_dir_up;
  logic                wrap;
  logic                pwm_on;

  assign wrap   = (prescaler == PRE_LAST);
  assign pwm_on = (&level) | (pwm_cnt < level);

  always_comb begin
    case (pend_mode)
      MODE_BLINK:              init_pattern = PAT_ONES;
      MODE_SHIFT, MODE_BOUNCE: init_pattern = PAT_FIRST;
      default:                 init_pattern = '0;
    endcase
  end

  // Bounce flips direction on arrival at an end so the end LED is shown once.
  always_comb begin
    step_pattern = '0;
    step_dir_up  = dir_up;
    case (mode)
      MODE_BLINK: step_pattern = (pattern == '0) ? PAT_ONES : '0;
      MODE_SHIFT: step_pattern = (pattern == '0) ? PAT_FIRST
                                 : {pattern[NUM_LEDS-2:0], pattern[NUM_LEDS-1]};
      MODE_BOUNCE: begin
        if (pattern == '0) begin
          step_pattern = PAT_FIRST;
          step_dir_up  = 1'b1;
        end else if (dir_up) begin
          step_pattern = pattern << 1;
          if (step_pattern[NUM_LEDS-1]) step_dir_up = 1'b0;
        end else begin
          step_pattern = pattern >> 1;
          if (step_pattern[0]) step_dir_up = 1'b1;
        end
      end
      default: step_pattern = '0;
    endcase
  end

  always_ff @(posedge clk_ext) begin
    if (!reset_n) begin
      state      <= ST_RUN;
      prescaler  <= '0;
      pwm_cnt    <= '0;
      tick       <= 1'b0;
      mode       <= MODE_OFF;
      level      <= '1;
      pend_mode  <= MODE_OFF;
      pend_level <= '1;
      pattern    <= '0;
      dir_up     <= 1'b1;
      cmd_ready  <= 1'b0;
      led        <= '0;
    end else begin
      prescaler <= wrap ? '0 : prescaler + PRE_W'(1);
      tick      <= wrap;
      pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
      led       <= pattern & {NUM_LEDS{pwm_on}};
      case (state)
        ST_RUN: begin
          if (wrap) begin
            pattern <= step_pattern;
            dir_up  <= step_dir_up;
          end
          if (cmd_valid && cmd_ready) begin
            pend_mode  <= cmd_mode;
            pend_level <= cmd_level;
            state      <= ST_PENDING;
            cmd_ready  <= 1'b0;
          end else begin
            cmd_ready  <= 1'b1;
          end
        end
        ST_PENDING: begin
          if (wrap) begin
            mode      <= pend_mode;
            level     <= pend_level;
            pattern   <= init_pattern;
            dir_up    <= 1'b1;
            state     <= ST_RUN;
            cmd_ready <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_artyz7_led_sequencer.sv
`default_nettype none
// ==== tb_artyz7_led_sequencer : command vectors with a queued LED scoreboard | rev 1.0 ====
module tb_artyz7_led_sequencer;

  logic       clk_ext   = 1'b0;
  logic       reset_n   = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_mode  = 2'd0;
  logic [3:0] cmd_level = 4'd0;
  logic       cmd_ready;
  logic [3:0] led;
  logic       tick;

  int         passed = 0;
  int         total  = 0;
  logic [3:0] pc     = 4'd0;
  logic [3:0] exp_q[$];

  typedef struct packed {
    logic [1:0]      mode;
    logic [3:0]      level;
    logic [3:0]      steps;
    logic            align;
    logic [7:0][3:0] seq;
  } vec_t;

  vec_t vecs[5];

  artyz7_led_sequencer #(
    .NUM_LEDS(4),
    .TICK_DIVIDER(4),
    .PWM_BITS(4)
  ) dut (
    .clk_ext(clk_ext),
    .reset_n(reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode),
    .cmd_level(cmd_level),
    .led(led),
    .tick(tick)
  );

  always #5 clk_ext = ~clk_ext;

  // Reference PWM phase: free-running count of cycles since reset release.
  always @(posedge clk_ext) pc <= reset_n ? pc + 4'd1 : 4'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic wait_tick(input logic align);
    int n = 0;
    do begin
      @(negedge clk_ext);
      n++;
    end while (!(tick && (!align || pc[2])) && n < 40);
    if (n >= 40) chk("tick_timeout", {31'd0, tick}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    logic [3:0] e;
    logic [3:0] step;
    logic       on;
    int         lit = 0;
    wait_tick(v.align);
    cmd_valid = 1'b1;
    cmd_mode  = v.mode;
    cmd_level = v.level;
    chk("ready_idle", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk_ext);
    cmd_valid = 1'b0;
    chk("ready_pending", {31'd0, cmd_ready}, 32'd0);
    repeat (2) @(negedge clk_ext);
    @(negedge clk_ext);
    chk("ready_applied", {31'd0, cmd_ready}, 32'd1);
    chk("tick_applied", {31'd0, tick}, 32'd1);
    for (int i = 0; i < 4 * int'(v.steps); i++) begin
      step = v.seq[i / 4];
      on   = (v.level == 4'hF) || (4'(pc + 4'(i)) < v.level);
      exp_q.push_back(on ? step : 4'h0);
    end
    while (exp_q.size() > 0) begin
      @(negedge clk_ext);
      e = exp_q.pop_front();
      chk("led", {28'd0, led}, {28'd0, e});
      if (led == 4'hF) lit++;
    end
    if (v.align) chk("pwm_lit_cycles", lit, 32'd8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{mode: 2'd2, level: 4'hF, steps: 4'd5, align: 1'b0, seq: 32'h0001_8421};
    vecs[1] = '{mode: 2'd3, level: 4'hF, steps: 4'd8, align: 1'b0, seq: 32'h2124_8421};
    vecs[2] = '{mode: 2'd1, level: 4'h4, steps: 4'd8, align: 1'b1, seq: 32'h0F0F_0F0F};
    vecs[3] = '{mode: 2'd1, level: 4'h0, steps: 4'd4, align: 1'b0, seq: 32'h0000_0F0F};
    vecs[4] = '{mode: 2'd0, level: 4'hF, steps: 4'd2, align: 1'b0, seq: 32'h0000_0000};

    // Reset held for three edges, then released.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_ext);
      chk("rst_led", {28'd0, led}, 32'd0);
      chk("rst_tick", {31'd0, tick}, 32'd0);
      chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_ext);
      chk("rel_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rel_tick", {31'd0, tick}, (i == 3) ? 32'd1 : 32'd0);
    end

    for (int k = 0; k < 5; k++) run_vec(vecs[k]);

    // Handshake on a wrap edge, second command held during PENDING.
    wait_tick(1'b0);
    repeat (3) @(negedge clk_ext);
    chk("wrap_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_mode  = 2'd2;
    cmd_level = 4'hF;
    @(negedge clk_ext);
    cmd_mode = 2'd1;
    chk("wrap_tick", {31'd0, tick}, 32'd1);
    chk("wrap_ready_drop", {31'd0, cmd_ready}, 32'd0);
    chk("wrap_led_old", {28'd0, led}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_ext);
      chk("pend_ignores_valid", {31'd0, cmd_ready}, 32'd0);
      chk("pend_led_old", {28'd0, led}, 32'd0);
    end
    @(negedge clk_ext);
    chk("apply_ready", {31'd0, cmd_ready}, 32'd1);
    chk("apply_tick", {31'd0, tick}, 32'd1);
    chk("apply_led_lag", {28'd0, led}, 32'd0);
    repeat (4) exp_q.push_back(4'h1);
    repeat (4) exp_q.push_back(4'hF);
    @(negedge clk_ext);
    cmd_valid = 1'b0;
    chk("second_accepted", {31'd0, cmd_ready}, 32'd0);
    chk("wrap_seq", {28'd0, led}, {28'd0, exp_q.pop_front()});
    while (exp_q.size() > 0) begin
      @(negedge clk_ext);
      chk("wrap_seq", {28'd0, led}, {28'd0, exp_q.pop_front()});
    end

    // Reset while a command is pending drops it.
    wait_tick(1'b0);
    cmd_valid = 1'b1;
    cmd_mode  = 2'd2;
    cmd_level = 4'hF;
    @(negedge clk_ext);
    cmd_valid = 1'b0;
    chk("prst_pending", {31'd0, cmd_ready}, 32'd0);
    reset_n = 1'b0;
    @(negedge clk_ext);
    chk("prst_led", {28'd0, led}, 32'd0);
    chk("prst_tick", {31'd0, tick}, 32'd0);
    chk("prst_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk_ext);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_ext);
      chk("prst_led_off", {28'd0, led}, 32'd0);
      chk("prst_ready_run", {31'd0, cmd_ready}, 32'd1);
      chk("prst_tick_phase", {31'd0, tick}, (i % 4 == 3) ? 32'd1 : 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
